// File: rtl/fft_mag_frame_ctrl.sv
// Frame sequencer between the FFT output stream and the CORDIC magnitude stage.
// Optional feature macro: MAG_PEAK_EN (peak magnitude/bin tracking of the buffered frame).
module fft_mag_frame_ctrl #(
    parameter int NFFT      = 2048,
    parameter int IDX_W     = 11,
    parameter int DATA_W    = 16,
    parameter int KEEP_BINS = 1024,
    parameter int FLUSH_TO  = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fft_tvalid,
    output logic                         fft_tready,
    input  logic                         fft_tlast,
    input  logic [IDX_W-1:0]             fft_tuser,
    output logic                         mag_in_valid,
    output logic                         mag_in_last,
    output logic [IDX_W-1:0]             mag_in_user,
    input  logic                         mag_out_valid,
    input  logic                         mag_out_last,
    input  logic [IDX_W-1:0]             mag_out_user,
    input  logic [DATA_W-1:0]            mag_out_data,
    output logic                         buf_we,
    output logic [$clog2(KEEP_BINS)-1:0] buf_waddr,
    output logic [DATA_W-1:0]            buf_wdata,
    output logic                         frame_ready,
    input  logic                         frame_ack,
    output logic [15:0]                  frame_count,
    output logic                         err_index,
    output logic                         err_last,
    output logic                         err_timeout,
    output logic [DATA_W-1:0]            peak_val,
    output logic [$clog2(KEEP_BINS)-1:0] peak_bin
);

    localparam int KA_W = $clog2(KEEP_BINS);
    localparam int FC_W = $clog2(FLUSH_TO + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFFT - 1);
    localparam logic [IDX_W:0]   KEEP_LIM = (IDX_W + 1)'(KEEP_BINS);

    typedef enum logic [1:0] {IDLE, FILL, FLUSH, READY} state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [IDX_W-1:0]    r_expIdx;
    logic                r_frameOk;
    logic [FC_W-1:0]     r_flushCnt;
    logic [15:0]         r_frameCount;
    logic                r_errIndex;
    logic                r_errLast;
    logic                r_errTimeout;
    logic                r_bufWe;
    logic [KA_W-1:0]     r_bufWaddr;
    logic [DATA_W-1:0]   r_bufWdata;

    logic                w_fwd;
    logic                w_start;
    logic                w_fillBeat;
    logic                w_idxBad;
    logic                w_lastBad;
    logic                w_magLast;
    logic                w_timeout;
    logic                w_bufWr;
    logic [KA_W-1:0]     w_binLo;

    assign w_start    = (r_state == IDLE) && fft_tvalid && (fft_tuser == '0);
    assign w_fillBeat = (r_state == FILL) && fft_tvalid;
    assign w_idxBad   = w_fillBeat && (fft_tuser != r_expIdx);
    assign w_lastBad  = w_fillBeat && (fft_tlast != (fft_tuser == LAST_IDX));
    assign w_magLast  = mag_out_valid && mag_out_last;
    assign w_timeout  = (r_state == FLUSH) && !w_magLast && (r_flushCnt == FC_W'(FLUSH_TO - 1));
    assign w_binLo    = mag_out_user[KA_W-1:0];
    assign w_bufWr    = mag_out_valid && ((r_state == FILL) || (r_state == FLUSH))
                        && ({1'b0, mag_out_user} < KEEP_LIM);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        fft_tready  = 1'b0;
        w_fwd       = 1'b0;
        case (r_state)
            IDLE: begin
                fft_tready = 1'b1;
                if (w_start) begin
                    w_fwd       = 1'b1;
                    w_nextState = FILL;
                end
            end
            FILL: begin
                fft_tready = 1'b1;
                w_fwd      = fft_tvalid && r_frameOk;
                if (w_fillBeat && (fft_tlast || (fft_tuser == LAST_IDX)))
                    w_nextState = FLUSH;
            end
            FLUSH: begin
                if (w_magLast)      w_nextState = r_frameOk ? READY : IDLE;
                else if (w_timeout) w_nextState = IDLE;
            end
            READY: begin
                if (frame_ack) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // A bad beat is still forwarded itself; frame_ok only gates the beats after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_expIdx     <= '0;
            r_frameOk    <= 1'b0;
            r_flushCnt   <= '0;
            r_frameCount <= '0;
            r_errIndex   <= 1'b0;
            r_errLast    <= 1'b0;
            r_errTimeout <= 1'b0;
        end else begin
            if (w_start) begin
                r_expIdx  <= IDX_W'(1);
                r_frameOk <= 1'b1;
            end else if (w_fillBeat) begin
                r_expIdx <= r_expIdx + IDX_W'(1);
                if (w_idxBad || w_lastBad) r_frameOk <= 1'b0;
            end
            if (w_idxBad)  r_errIndex   <= 1'b1;
            if (w_lastBad) r_errLast    <= 1'b1;
            if (w_timeout) r_errTimeout <= 1'b1;
            r_flushCnt <= (r_state == FLUSH) ? r_flushCnt + FC_W'(1) : '0;
            if ((r_state == READY) && frame_ack) r_frameCount <= r_frameCount + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bufWe    <= 1'b0;
            r_bufWaddr <= '0;
            r_bufWdata <= '0;
        end else begin
            r_bufWe <= w_bufWr;
            if (w_bufWr) begin
                r_bufWaddr <= w_binLo;
                r_bufWdata <= mag_out_data;
            end
        end
    end

`ifdef MAG_PEAK_EN
    logic [DATA_W-1:0] r_peakVal;
    logic [KA_W-1:0]   r_peakBin;

    // Equal values only replace the held peak when they come from a lower bin.
    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            r_peakVal <= '0;
            r_peakBin <= '0;
        end else if (w_bufWr && ((mag_out_data > r_peakVal) ||
                                 ((mag_out_data == r_peakVal) && (w_binLo < r_peakBin)))) begin
            r_peakVal <= mag_out_data;
            r_peakBin <= w_binLo;
        end
    end

    assign peak_val = r_peakVal;
    assign peak_bin = r_peakBin;
`else
    assign peak_val = '0;
    assign peak_bin = '0;
`endif

    assign mag_in_valid = w_fwd;
    assign mag_in_last  = w_fwd && fft_tlast;
    assign mag_in_user  = fft_tuser;
    assign buf_we       = r_bufWe;
    assign buf_waddr    = r_bufWaddr;
    assign buf_wdata    = r_bufWdata;
    assign frame_ready  = (r_state == READY);
    assign frame_count  = r_frameCount;
    assign err_index    = r_errIndex;
    assign err_last     = r_errLast;
    assign err_timeout  = r_errTimeout;

endmodule

// File: tb/tb_fft_mag_frame_ctrl.sv
// Scoreboard bench for fft_mag_frame_ctrl with a delay-line magnitude model and random frames.
// Expected peak values follow MAG_PEAK_EN.
module tb_fft_mag_frame_ctrl;

    localparam int NFFT      = 2048;
    localparam int IDX_W     = 11;
    localparam int DATA_W    = 16;
    localparam int KEEP_BINS = 1024;
    localparam int KA_W      = 10;
    localparam int FLUSH_TO  = 64;
    localparam int MAG_LAT   = 20;

    logic              clk;
    logic              reset;
    logic              fft_tvalid;
    logic              fft_tready;
    logic              fft_tlast;
    logic [IDX_W-1:0]  fft_tuser;
    logic              mag_in_valid;
    logic              mag_in_last;
    logic [IDX_W-1:0]  mag_in_user;
    logic              mag_out_valid;
    logic              mag_out_last;
    logic [IDX_W-1:0]  mag_out_user;
    logic [DATA_W-1:0] mag_out_data;
    logic              buf_we;
    logic [KA_W-1:0]   buf_waddr;
    logic [DATA_W-1:0] buf_wdata;
    logic              frame_ready;
    logic              frame_ack;
    logic [15:0]       frame_count;
    logic              err_index;
    logic              err_last;
    logic              err_timeout;
    logic [DATA_W-1:0] peak_val;
    logic [KA_W-1:0]   peak_bin;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] magTable [NFFT];
    bit                frameActive = 0;
    bit                dropLast = 0;
    int                negCyc = 0;
    int                writesSeen = 0;
    int                dueQ[$];
    logic [IDX_W-1:0]  userQ[$];
    bit                lastQ[$];
    logic [KA_W-1:0]   expAddrQ[$];
    logic [DATA_W-1:0] expDataQ[$];

    fft_mag_frame_ctrl dut (
        .clk(clk), .reset(reset),
        .fft_tvalid(fft_tvalid), .fft_tready(fft_tready), .fft_tlast(fft_tlast), .fft_tuser(fft_tuser),
        .mag_in_valid(mag_in_valid), .mag_in_last(mag_in_last), .mag_in_user(mag_in_user),
        .mag_out_valid(mag_out_valid), .mag_out_last(mag_out_last),
        .mag_out_user(mag_out_user), .mag_out_data(mag_out_data),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .frame_ready(frame_ready), .frame_ack(frame_ack), .frame_count(frame_count),
        .err_index(err_index), .err_last(err_last), .err_timeout(err_timeout),
        .peak_val(peak_val), .peak_bin(peak_bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Magnitude stage model: fixed latency, optionally loses the frame's last beat.
    initial begin
        logic [IDX_W-1:0] u;
        bit l;
        mag_out_valid = 1'b0;
        mag_out_last  = 1'b0;
        mag_out_user  = '0;
        mag_out_data  = '0;
        forever begin
            @(negedge clk);
            negCyc++;
            if (mag_in_valid && !(dropLast && mag_in_last)) begin
                dueQ.push_back(negCyc + MAG_LAT);
                userQ.push_back(mag_in_user);
                lastQ.push_back(mag_in_last);
            end
            if (dueQ.size() > 0 && dueQ[0] <= negCyc) begin
                void'(dueQ.pop_front());
                u = userQ.pop_front();
                l = lastQ.pop_front();
                mag_out_valid = 1'b1;
                mag_out_last  = l;
                mag_out_user  = u;
                mag_out_data  = magTable[u];
                if (frameActive && (int'(u) < KEEP_BINS)) begin
                    expAddrQ.push_back(u[KA_W-1:0]);
                    expDataQ.push_back(magTable[u]);
                end
            end else begin
                mag_out_valid = 1'b0;
                mag_out_last  = 1'b0;
            end
        end
    end

    // Buffer-write monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (buf_we) begin
                if (expAddrQ.size() == 0) begin
                    checkOutput("unexpected_buf_we", 32'(buf_we), 32'd0);
                end else begin
                    checkOutput("buf_waddr", 32'(buf_waddr), 32'(expAddrQ.pop_front()));
                    checkOutput("buf_wdata", 32'(buf_wdata), 32'(expDataQ.pop_front()));
                    writesSeen++;
                end
            end
        end
    end

    task automatic doReset();
        @(posedge clk); #1;
        reset = 1'b1;
        fft_tvalid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input int user, input bit last, input int expFwd);
        if ($urandom_range(0, 7) == 0) begin
            @(posedge clk); #1;
            fft_tvalid = 1'b0;
        end
        @(posedge clk); #1;
        fft_tvalid = 1'b1;
        fft_tuser  = IDX_W'(user);
        fft_tlast  = last;
        if (expFwd >= 0) begin
            #1;
            checkOutput("mag_in_valid", 32'(mag_in_valid), 32'(expFwd));
        end
    endtask

    task automatic endBeats();
        @(posedge clk); #1;
        fft_tvalid = 1'b0;
        fft_tlast  = 1'b0;
    endtask

    task automatic sendFrame(input int lastIdx, input bit markLast, input int skip, input int fwdChk);
        for (int i = 0; i <= lastIdx; i++) begin
            if (i != skip) applyStimulus(i, markLast && (i == lastIdx), (i == 0) ? fwdChk : -1);
        end
        endBeats();
    endtask

    task automatic fillTable(input int maxVal);
        for (int i = 0; i < NFFT; i++) magTable[i] = DATA_W'($urandom_range(0, maxVal));
    endtask

    task automatic waitReady(output bit seen);
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (frame_ready) seen = 1;
        end
        checkOutput("frame_ready_reached", 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    // Counts cycles with fft_tready low until it returns high; notes any frame_ready.
    task automatic waitBackpressure(output int lowCnt, output bit readySeen);
        bit done;
        lowCnt = 0;
        readySeen = 0;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (frame_ready) readySeen = 1;
            if (!fft_tready) lowCnt++;
            else if (lowCnt > 0) done = 1;
        end
        checkOutput("tready_returned", 32'(done), 32'd1);
    endtask

    task automatic checkPeak();
        logic [DATA_W-1:0] bestVal;
        logic [KA_W-1:0]   bestBin;
        bestVal = '0;
        bestBin = '0;
`ifdef MAG_PEAK_EN
        for (int i = 0; i < KEEP_BINS; i++) begin
            if (magTable[i] > bestVal) begin
                bestVal = magTable[i];
                bestBin = KA_W'(i);
            end
        end
`endif
        checkOutput("peak_val", 32'(peak_val), 32'(bestVal));
        checkOutput("peak_bin", 32'(peak_bin), 32'(bestBin));
    endtask

    task automatic ackFrame(input int expCount);
        @(posedge clk); #1;
        frame_ack = 1'b1;
        @(posedge clk); #1;
        frame_ack = 1'b0;
        checkOutput("frame_ready_after_ack", 32'(frame_ready), 32'd0);
        checkOutput("frame_count", 32'(frame_count), 32'(expCount));
        checkOutput("tready_after_ack", 32'(fft_tready), 32'd1);
    endtask

    task automatic goodFrame(input int expCount, input int fwdChk);
        bit seen;
        writesSeen = 0;
        frameActive = 1;
        sendFrame(NFFT - 1, 1, -1, fwdChk);
        waitReady(seen);
        checkOutput("writes_per_frame", 32'(writesSeen), 32'(KEEP_BINS));
        checkOutput("err_index_clean", 32'(err_index), 32'd0);
        checkOutput("err_last_clean", 32'(err_last), 32'd0);
        checkOutput("err_timeout_clean", 32'(err_timeout), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("frame_ready_hold", 32'(frame_ready), 32'd1);
            checkOutput("tready_in_ready", 32'(fft_tready), 32'd0);
            checkPeak();
        end
        ackFrame(expCount);
    endtask

    initial begin
        int lowCnt;
        bit readySeen;
        reset = 1'b1;
        fft_tvalid = 1'b0;
        fft_tlast = 1'b0;
        fft_tuser = '0;
        frame_ack = 1'b0;
        for (int i = 0; i < NFFT; i++) magTable[i] = '0;
        doReset();

        @(negedge clk);
        checkOutput("rst_tready", 32'(fft_tready), 32'd1);
        checkOutput("rst_frame_ready", 32'(frame_ready), 32'd0);
        checkOutput("rst_buf_we", 32'(buf_we), 32'd0);
        checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
        checkOutput("rst_errs", 32'({err_index, err_last, err_timeout}), 32'd0);
        checkOutput("rst_peak", 32'({peak_val, peak_bin}), 32'd0);

        @(posedge clk); #1;
        frame_ack = 1'b1;
        @(posedge clk); #1;
        frame_ack = 1'b0;
        checkOutput("ack_in_idle_ignored", 32'(frame_count), 32'd0);

        $display("[TB] clean frame, random magnitudes");
        fillTable(65535);
        goodFrame(1, 1);

        $display("[TB] resync beats then frame with many ties");
        fillTable(15);
        applyStimulus(5, 0, 0);
        applyStimulus(6, 0, 0);
        applyStimulus(7, 0, 0);
        goodFrame(2, 1);
        checkOutput("resync_err_index", 32'(err_index), 32'd0);

        $display("[TB] index gap at 100");
        fillTable(65535);
        frameActive = 1;
        sendFrame(NFFT - 1, 1, 100, -1);
        waitBackpressure(lowCnt, readySeen);
        checkOutput("gap_err_index", 32'(err_index), 32'd1);
        checkOutput("gap_no_frame_ready", 32'(readySeen), 32'd0);
        checkOutput("gap_frame_count", 32'(frame_count), 32'd2);

        $display("[TB] early tlast at 1500");
        doReset();
        sendFrame(1500, 1, -1, -1);
        @(negedge clk);
        checkOutput("early_tready_low", 32'(fft_tready), 32'd0);
        waitBackpressure(lowCnt, readySeen);
        checkOutput("early_err_last", 32'(err_last), 32'd1);
        checkOutput("early_err_timeout", 32'(err_timeout), 32'd0);
        checkOutput("early_no_frame_ready", 32'(readySeen), 32'd0);
        checkOutput("early_left_before_timeout", 32'(lowCnt < FLUSH_TO), 32'd1);

        $display("[TB] flush timeout");
        doReset();
        dropLast = 1;
        sendFrame(NFFT - 1, 1, -1, -1);
        waitBackpressure(lowCnt, readySeen);
        dropLast = 0;
        checkOutput("timeout_flush_cycles", 32'(lowCnt), 32'(FLUSH_TO));
        checkOutput("timeout_err", 32'(err_timeout), 32'd1);
        checkOutput("timeout_no_frame_ready", 32'(readySeen), 32'd0);
        checkOutput("timeout_errs_other", 32'({err_index, err_last}), 32'd0);

        $display("[TB] reset mid-frame at bin 800");
        doReset();
        frameActive = 1;
        sendFrame(800, 0, -1, -1);
        reset = 1'b1;
        frameActive = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checkOutput("midrst_buf_we", 32'(buf_we), 32'd0);
            checkOutput("midrst_frame_ready", 32'(frame_ready), 32'd0);
        end
        checkOutput("midrst_errs", 32'({err_index, err_last, err_timeout}), 32'd0);

        $display("[TB] impulse at bin 37");
        for (int i = 0; i < NFFT; i++) magTable[i] = '0;
        magTable[37] = 16'h1234;
        magTable[1500] = 16'hFFFF;
        goodFrame(1, 1);

        checkOutput("pending_writes", 32'(expAddrQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_mag_frame_ctrl.md
Name: fft_mag_frame_ctrl

Overview:
- Frame-level sequencer between the FFT core output stream and the CORDIC magnitude stage.
- Admits exactly one NFFT-point frame at a time and checks bin-index continuity.
- Writes the lower KEEP_BINS magnitudes into a single spectrum buffer, then holds the frame for the downstream conv layer until it is acknowledged.
- Applies backpressure to the FFT core while the magnitude pipeline drains and while the buffer is owned downstream.

Parameters:
- NFFT, 2048, points per FFT frame.
- IDX_W, 11, bin index width; log2(NFFT).
- DATA_W, 16, magnitude word width.
- KEEP_BINS, 1024, bins 0..KEEP_BINS-1 are written to the buffer; the rest are dropped.
- FLUSH_TO, 64, maximum cycles in FLUSH waiting for the magnitude stage's last beat.

Ports:
- clk  in  1  clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- fft_tvalid  in  1  FFT output beat valid.
- fft_tready  out  1  controller accepts FFT beat.
- fft_tlast  in  1  FFT last beat of frame.
- fft_tuser  in  IDX_W  FFT bin index.
- mag_in_valid  out  1  valid into magnitude stage; equals fft_tvalid & fft_tready & state==FILL & frame_ok.
- mag_in_last  out  1  fft_tlast passthrough, qualified like mag_in_valid.
- mag_in_user  out  IDX_W  fft_tuser passthrough.
- mag_out_valid  in  1  magnitude result valid.
- mag_out_last  in  1  magnitude last.
- mag_out_user  in  IDX_W  magnitude bin index.
- mag_out_data  in  DATA_W  magnitude value.
- buf_we  out  1  buffer write enable.
- buf_waddr  out  log2(KEEP_BINS)  buffer address.
- buf_wdata  out  DATA_W  buffer data.
- frame_ready  out  1  buffer holds a complete good frame.
- frame_ack  in  1  single-cycle pulse; downstream releases the buffer.
- frame_count  out  16  good frames completed; wraps at 0xFFFF->0.
- err_index  out  1  sticky; index discontinuity seen.
- err_last  out  1  sticky; tlast at index != NFFT-1, or index NFFT-1 without tlast.
- err_timeout  out  1  sticky; FLUSH exceeded FLUSH_TO.
- peak_val  out  DATA_W  see Optional Feature.
- peak_bin  out  log2(KEEP_BINS)  see Optional Feature.

Behaviour:
- Reset: state=IDLE; all outputs 0 except pass-through wires; sticky errors, frame_count and expected index cleared.
- Clock and reset: one clock (clk); reset is synchronous and active-high, and a single reset cycle is sufficient.
- States: IDLE, FILL, FLUSH, READY.
- IDLE:
  - fft_tready=1.
  - Beat with tuser==0: forward it to the magnitude stage, set exp_idx=1, enter FILL.
  - Beat with tuser!=0: consume it, do not forward it, stay in IDLE (resync); err_index is not set.
- FILL:
  - fft_tready=1; every accepted beat is forwarded.
  - tuser!=exp_idx: set err_index, clear frame_ok. Subsequent beats are consumed but not forwarded.
  - On accepted tlast: enter FLUSH and start the flush counter. If tuser!=NFFT-1, set err_last and clear frame_ok.
  - Accepted tuser==NFFT-1 without tlast: set err_last, clear frame_ok, enter FLUSH.
- FLUSH:
  - fft_tready=0.
  - Stay until mag_out_valid&mag_out_last is seen. Then go to READY if frame_ok, otherwise to IDLE.
  - Counter reaches FLUSH_TO: set err_timeout, enter IDLE.
- Buffer writes (FILL and FLUSH only):
  - mag_out_valid & mag_out_user<KEEP_BINS gives buf_we=1, buf_waddr=mag_out_user[low bits], buf_wdata=mag_out_data, registered (1-cycle latency).
  - Outputs arriving in IDLE or READY, e.g. stale results after reset, are ignored.
- READY:
  - fft_tready=0, frame_ready=1.
  - frame_ack: frame_ready drops the next cycle, frame_count increments, state goes to IDLE.
- frame_ack outside READY is ignored.
- fft_tvalid & fft_tready with the same-cycle mag_out_last in FILL: both are processed; the write happens and the FILL transitions still apply.
- Reset mid-frame: immediate return to IDLE; the buffer contents are undefined; frame_ready=0.

Optional Feature:
- Macro MAG_PEAK_EN.
- Defined:
  - Tracks the maximum of the buffered magnitudes (unsigned) and its bin during FILL/FLUSH; cleared on entry to FILL.
  - Ties go to the lowest bin.
  - peak_val/peak_bin are valid while frame_ready=1 and hold their values until the next FILL entry.
- Undefined: peak_val=0 and peak_bin=0 constantly; no comparator logic is generated.

Test Plan:
- Clean frame: 2048 beats with tuser 0..2047 and tlast on 2047; magnitude model latency 20 -> 1024 writes to addr 0..1023, frame_ready=1, no errors; frame_ack -> frame_count=1, fft_tready=1.
- Resync: beats with tuser 5,6,7 in IDLE, then 0..2047 -> the first three are not forwarded (mag_in_valid=0), then a normal frame; err_index=0.
- Index gap: frame skips index 100 -> err_index=1; state FLUSH then IDLE without frame_ready; frame_count unchanged.
- Early tlast at tuser=1500 -> err_last=1, no frame_ready; fft_tready=0 until the magnitude last arrives, then 1.
- Timeout: magnitude model drops its last beat -> after 64 FLUSH cycles err_timeout=1, state IDLE.
- Reset asserted at bin 800, magnitude outputs still arriving -> buf_we stays 0 and frame_ready=0. With MAG_PEAK_EN and an impulse of 0x1234 at bin 37: peak_val=0x1234, peak_bin=37.
